// File: rtl/scaler_clock_pkg.sv
// Shared constants for the scaler clock generator and the scaler latch logic.
// Reset defaults give 33.333 MHz -> 1 kHz ticks and 1 s windows.
package scaler_clock_pkg;

    localparam int unsigned DEFAULT_DIV = 33333;
    localparam int unsigned DEFAULT_WIN = 1000;
    localparam int unsigned MIN_DIV     = 2;
    localparam int unsigned MIN_WIN     = 1;

endpackage

// File: rtl/scaler_tc_counter.sv
// Generic terminal-count counter: counts 0..term, wraps, and emits a registered tc pulse.
// A sync-clear restarts the count and suppresses any tc in the same cycle.
module scaler_tc_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] cnt,
    output logic             at_term,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    assign at_term = (cnt_q == term);
    assign cnt     = cnt_q;
    assign tc      = tc_q;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (at_term) begin
                cnt_d = '0;
                tc_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

endmodule

// File: rtl/scaler_clock_gen.sv
// kHz clock, kHz tick and scaler window strobe generator with runtime-loadable
// divide ratio and window length, applied only at window boundaries or on sync.
module scaler_clock_gen #(
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = scaler_clock_pkg::DEFAULT_DIV,
    parameter int unsigned WIN_WIDTH   = 10,
    parameter int unsigned DEFAULT_WIN = scaler_clock_pkg::DEFAULT_WIN
) (
    input  logic                 clk33_i,
    input  logic                 rst_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [WIN_WIDTH-1:0] win_i,
    input  logic                 load_i,
    input  logic                 sync_i,
    output logic                 load_ack_o,
    output logic                 khz_clk_o,
    output logic                 khz_tick_o,
    output logic                 win_tick_o,
    output logic [WIN_WIDTH-1:0] win_cnt_o
);

    import scaler_clock_pkg::*;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(MIN_DIV);
    localparam logic [WIN_WIDTH-1:0] WIN_MIN = WIN_WIDTH'(MIN_WIN);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [WIN_WIDTH-1:0] WIN_RST = WIN_WIDTH'(DEFAULT_WIN);

    logic [DIV_WIDTH-1:0] div_cur_q, div_cur_d, div_pend_q, div_pend_d, div_req;
    logic [WIN_WIDTH-1:0] win_cur_q, win_cur_d, win_pend_q, win_pend_d, win_req;
    logic                 pend_q, pend_d;
    logic                 ack_q, ack_d;
    logic                 clk_q, clk_d;

    logic [DIV_WIDTH-1:0] pre_cnt, pre_term, pre_next, div_half;
    logic [WIN_WIDTH-1:0] win_term;
    logic                 pre_at_term, win_at_term, win_wrap;

    // Clamp at capture time so the active values are always legal.
    assign div_req  = (div_i < DIV_MIN) ? DIV_MIN : div_i;
    assign win_req  = (win_i < WIN_MIN) ? WIN_MIN : win_i;

    assign pre_term = div_cur_q - 1'b1;
    assign win_term = win_cur_q - 1'b1;
    assign div_half = div_cur_q >> 1;
    assign win_wrap = pre_at_term & win_at_term & ~sync_i;

    // Next prescale count; every restart lands on 0, which is always in the high half.
    assign pre_next = (sync_i | pre_at_term) ? '0 : pre_cnt + 1'b1;

    scaler_tc_counter #(
        .WIDTH (DIV_WIDTH)
    ) u_pre_cnt (
        .clk     (clk33_i),
        .rst     (rst_i),
        .en      (1'b1),
        .clr     (sync_i),
        .term    (pre_term),
        .cnt     (pre_cnt),
        .at_term (pre_at_term),
        .tc      (khz_tick_o)
    );

    scaler_tc_counter #(
        .WIDTH (WIN_WIDTH)
    ) u_win_cnt (
        .clk     (clk33_i),
        .rst     (rst_i),
        .en      (pre_at_term),
        .clr     (sync_i),
        .term    (win_term),
        .cnt     (win_cnt_o),
        .at_term (win_at_term),
        .tc      (win_tick_o)
    );

    always_comb begin
        div_cur_d  = div_cur_q;
        win_cur_d  = win_cur_q;
        div_pend_d = div_pend_q;
        win_pend_d = win_pend_q;
        pend_d     = pend_q;
        ack_d      = 1'b0;
        if (sync_i) begin
            pend_d = 1'b0;
            if (load_i) begin
                div_cur_d = div_req;
                win_cur_d = win_req;
                ack_d     = 1'b1;
            end else if (pend_q) begin
                div_cur_d = div_pend_q;
                win_cur_d = win_pend_q;
                ack_d     = 1'b1;
            end
        end else begin
            if (win_wrap && pend_q) begin
                div_cur_d = div_pend_q;
                win_cur_d = win_pend_q;
                ack_d     = 1'b1;
                pend_d    = 1'b0;
            end
            // A load on the boundary cycle stages for the following window.
            if (load_i) begin
                div_pend_d = div_req;
                win_pend_d = win_req;
                pend_d     = 1'b1;
            end
        end
        clk_d = (pre_next < div_half);
    end

    always_ff @(posedge clk33_i or posedge rst_i) begin
        if (rst_i) begin
            div_cur_q  <= DIV_RST;
            win_cur_q  <= WIN_RST;
            div_pend_q <= '0;
            win_pend_q <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            clk_q      <= 1'b0;
        end else begin
            div_cur_q  <= div_cur_d;
            win_cur_q  <= win_cur_d;
            div_pend_q <= div_pend_d;
            win_pend_q <= win_pend_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            clk_q      <= clk_d;
        end
    end

    assign load_ack_o = ack_q;
    assign khz_clk_o  = clk_q;

endmodule

// File: tb/tb_scaler_clock_gen.sv
// Bench for scaler_clock_gen: directed scenarios plus random load/sync traffic,
// checked every cycle against an elapsed-time arithmetic model.
module tb_scaler_clock_gen;

    localparam int unsigned DW   = 16;
    localparam int unsigned WW   = 10;
    localparam int unsigned DDIV = 10;
    localparam int unsigned DWIN = 4;

    logic          clk33 = 1'b0;
    logic          rst, load, sync;
    logic [DW-1:0] div;
    logic [WW-1:0] win;
    logic          load_ack, khz_clk, khz_tick, win_tick;
    logic [WW-1:0] win_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model state: edges since reset, edge of last period restart, active/pending config.
    int unsigned m_n, m_base, m_dv, m_wn, m_pdv, m_pwn;
    bit          m_pv, e_tick, e_wtick, e_ack;

    scaler_clock_gen #(
        .DIV_WIDTH   (DW),
        .DEFAULT_DIV (DDIV),
        .WIN_WIDTH   (WW),
        .DEFAULT_WIN (DWIN)
    ) dut (
        .clk33_i    (clk33),
        .rst_i      (rst),
        .div_i      (div),
        .win_i      (win),
        .load_i     (load),
        .sync_i     (sync),
        .load_ack_o (load_ack),
        .khz_clk_o  (khz_clk),
        .khz_tick_o (khz_tick),
        .win_tick_o (win_tick),
        .win_cnt_o  (win_cnt)
    );

    always #5 clk33 = ~clk33;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, m_n, got, exp);
        end
    endtask

    function automatic int unsigned cdiv(input int unsigned d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int unsigned cwin(input int unsigned w);
        return (w < 1) ? 1 : w;
    endfunction

    task automatic model_reset();
        m_n = 0; m_base = 0; m_dv = DDIV; m_wn = DWIN; m_pv = 0;
        m_pdv = 0; m_pwn = 0; e_tick = 0; e_wtick = 0; e_ack = 0;
    endtask

    task automatic model_edge(input bit l, input bit s, input int unsigned d,
                              input int unsigned w);
        int unsigned e;
        m_n++;
        e_tick = 0; e_wtick = 0; e_ack = 0;
        if (s) begin
            if (l) begin
                m_dv = cdiv(d); m_wn = cwin(w); e_ack = 1;
            end else if (m_pv) begin
                m_dv = m_pdv; m_wn = m_pwn; e_ack = 1;
            end
            m_pv = 0;
            m_base = m_n;
        end else begin
            e = m_n - m_base;
            e_tick  = (e % m_dv == 0);
            e_wtick = e_tick && (e / m_dv == m_wn);
            if (e_wtick) begin
                if (m_pv) begin
                    m_dv = m_pdv; m_wn = m_pwn; e_ack = 1;
                end
                m_pv = 0;
                m_base = m_n;
            end
            if (l) begin
                m_pdv = cdiv(d); m_pwn = cwin(w); m_pv = 1;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        int unsigned e, x_cnt, x_clk;
        e = m_n - m_base;
        if (m_n == 0) begin
            x_cnt = 0; x_clk = 0;
        end else begin
            x_cnt = e / m_dv;
            x_clk = ((e % m_dv) < (m_dv / 2)) ? 1 : 0;
        end
        check({ph, ":khz_tick"}, 32'(khz_tick), 32'(e_tick));
        check({ph, ":win_tick"}, 32'(win_tick), 32'(e_wtick));
        check({ph, ":load_ack"}, 32'(load_ack), 32'(e_ack));
        check({ph, ":win_cnt"}, 32'(win_cnt), x_cnt);
        check({ph, ":khz_clk"}, 32'(khz_clk), x_clk);
    endtask

    task automatic step(input string ph, input bit l, input bit s, input int unsigned d,
                        input int unsigned w);
        load = l; sync = s; div = DW'(d); win = WW'(w);
        @(posedge clk33);
        model_edge(l, s, d, w);
        #1;
        load = 1'b0; sync = 1'b0;
        compare_all(ph);
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst:khz_tick", 32'(khz_tick), 0);
        check("async_rst:win_tick", 32'(win_tick), 0);
        check("async_rst:load_ack", 32'(load_ack), 0);
        check("async_rst:win_cnt", 32'(win_cnt), 0);
        check("async_rst:khz_clk", 32'(khz_clk), 0);
        @(posedge clk33);
        @(posedge clk33);
        #1;
        rst = 1'b0;
        model_reset();
        compare_all("rst_state");
    endtask

    bit          r_l, r_s;
    int unsigned r_d, r_w;

    initial begin
        rst = 1'b1; load = 1'b0; sync = 1'b0; div = '0; win = '0;
        model_reset();
        @(posedge clk33);
        @(posedge clk33);
        #1;
        rst = 1'b0;
        compare_all("rst_state");

        // Default timing, then a 6/3 load at edge 15 applied at the edge-40 boundary.
        for (int i = 1; i <= 70; i++) step("load_6_3", i == 15, 0, 6, 3);

        // Clamped 0/0 load applied by sync.
        do_reset();
        for (int i = 1; i <= 6; i++) step("clamp", i == 3, 0, 0, 0);
        step("clamp_sync", 0, 1, 0, 0);
        for (int i = 1; i <= 12; i++) step("clamp_run", 0, 0, 0, 0);

        // Sync exactly on the terminal edge 20.
        do_reset();
        for (int i = 1; i <= 19; i++) step("pre_sync", 0, 0, 0, 0);
        step("sync_tc", 0, 1, 0, 0);
        for (int i = 1; i <= 25; i++) step("post_sync", 0, 0, 0, 0);

        // Two loads in one window: only the last is applied.
        do_reset();
        for (int i = 1; i <= 70; i++) step("two_loads", i == 5 || i == 12, 0, i == 5 ? 6 : 8, 3);

        // Reset mid-window with a pending load.
        do_reset();
        for (int i = 1; i <= 25; i++) step("pend", i == 5, 0, 4, 2);
        do_reset();
        for (int i = 1; i <= 45; i++) step("after_rst", 0, 0, 0, 0);

        // Random load/sync traffic, including simultaneous load+sync and boundary loads.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            r_l = ($urandom_range(0, 29) == 0);
            r_s = ($urandom_range(0, 79) == 0);
            r_d = $urandom_range(0, 12);
            r_w = $urandom_range(0, 5);
            step("random", r_l, r_s, r_d, r_w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
